// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - frame-buffer write arbiter: Painter/CPU/clear sequencer with main/special decode
// Optional macro ARB_FIXED_PRIO_EN: Painter always wins contention instead of round-robin.
module fb_write_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int MAIN_SIZE = 36800,
    parameter int SPEC_SIZE = 1600,
    parameter int SPEC_W    = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [2:0]        p_data,
    output logic              p_ack,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [2:0]        c_data,
    output logic              c_ack,
    input  logic              clr_start,
    input  logic [2:0]        clr_color,
    output logic              clr_busy,
    output logic              main_we,
    output logic [ADDR_W-1:0] main_addr,
    output logic [2:0]        main_data,
    output logic              spec_we,
    output logic [SPEC_W-1:0] spec_addr,
    output logic [2:0]        spec_data,
    output logic              err_oob
);

    localparam logic [ADDR_W-1:0] MAIN_END  = ADDR_W'(MAIN_SIZE);
    localparam logic [ADDR_W-1:0] TOTAL_END = ADDR_W'(MAIN_SIZE + SPEC_SIZE);
    localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(MAIN_SIZE + SPEC_SIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [2:0]        clr_col;
    logic              p_win;
    logic              open;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              hit_main;
    logic              hit_spec;
    logic              hit_oob;
    logic [SPEC_W-1:0] spec_off;

`ifdef ARB_FIXED_PRIO_EN
    assign p_win = 1'b1;
`else
    logic last_cpu;
    // Painter wins a tie only when the CPU was served most recently.
    assign p_win = last_cpu;
`endif

    always_comb begin
        open  = reset && (state == IDLE) && !clr_start;
        p_ack = open && p_req && (!c_req || p_win);
        c_ack = open && c_req && (!p_req || !p_win);
    end

    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = p_addr;
        wr_data  = p_data;
        if (state == CLEAR) begin
            wr_valid = 1'b1;
            wr_addr  = cnt;
            wr_data  = clr_col;
        end else if (p_ack) begin
            wr_valid = 1'b1;
        end else if (c_ack) begin
            wr_valid = 1'b1;
            wr_addr  = c_addr;
            wr_data  = c_data;
        end
    end

    always_comb begin
        hit_main = wr_valid && (wr_addr < MAIN_END);
        hit_spec = wr_valid && !hit_main && (wr_addr < TOTAL_END);
        hit_oob  = wr_valid && (wr_addr >= TOTAL_END);
        spec_off = SPEC_W'(wr_addr - MAIN_END);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            clr_col   <= '0;
            clr_busy  <= 1'b0;
            main_we   <= 1'b0;
            main_addr <= '0;
            main_data <= '0;
            spec_we   <= 1'b0;
            spec_addr <= '0;
            spec_data <= '0;
            err_oob   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_cpu  <= 1'b1;
`endif
        end else begin
            main_we <= hit_main;
            spec_we <= hit_spec;
            if (hit_main) begin
                main_addr <= wr_addr;
                main_data <= wr_data;
            end
            if (hit_spec) begin
                spec_addr <= spec_off;
                spec_data <= wr_data;
            end
            if (hit_oob) begin
                err_oob <= 1'b1;
            end
`ifndef ARB_FIXED_PRIO_EN
            if (p_ack) begin
                last_cpu <= 1'b0;
            end else if (c_ack) begin
                last_cpu <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        clr_col  <= clr_color;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_CNT) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - self-checking bench for fb_write_arbiter against a behavioural model
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_req, c_req, clr_start;
    logic [15:0] p_addr, c_addr;
    logic [2:0]  p_data, c_data, clr_color;
    logic        p_ack, c_ack, clr_busy, main_we, spec_we, err_oob;
    logic [15:0] main_addr;
    logic [10:0] spec_addr;
    logic [2:0]  main_data, spec_data;

    always #5 clk = ~clk;

    fb_write_arbiter dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_addr(p_addr), .p_data(p_data), .p_ack(p_ack),
        .c_req(c_req), .c_addr(c_addr), .c_data(c_data), .c_ack(c_ack),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .main_we(main_we), .main_addr(main_addr), .main_data(main_data),
        .spec_we(spec_we), .spec_addr(spec_addr), .spec_data(spec_data),
        .err_oob(err_oob)
    );

    int chk_total = 0;
    int chk_pass  = 0;

    // Reference model state, expressed as plain integers and flags.
    bit       m_clearing = 0;
    int       m_cnt = 0;
    bit [2:0] m_col = 0;
    bit       m_last_cpu = 1;
    bit       m_main_we = 0, m_spec_we = 0, m_err = 0, m_busy = 0;
    int       m_main_addr = 0, m_spec_addr = 0;
    bit [2:0] m_main_data = 0, m_spec_data = 0;
    bit       e_p_ack = 0, e_c_ack = 0;
    int       n_main = 0, n_spec = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_total++;
        assert (obs === exp) chk_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 16'd0;
            1: return 16'd36799;
            2: return 16'd36800;
            3: return 16'd38399;
            4: return 16'd38400;
            5: return 16'd65535;
            default: return 16'($urandom_range(0, 38399));
        endcase
    endfunction

    task automatic cycle();
        bit       v;
        int       a;
        bit [2:0] d;
        #1;
        e_p_ack = 0;
        e_c_ack = 0;
        if (reset && !m_clearing && !clr_start) begin
            if (p_req && c_req) begin
`ifdef ARB_FIXED_PRIO_EN
                e_p_ack = 1;
`else
                if (m_last_cpu) e_p_ack = 1;
                else e_c_ack = 1;
`endif
            end else begin
                e_p_ack = p_req;
                e_c_ack = c_req;
            end
        end
        check("p_ack", p_ack, e_p_ack);
        check("c_ack", c_ack, e_c_ack);
        v = 0; a = 0; d = 0;
        if (!reset) begin
            m_clearing = 0; m_cnt = 0; m_col = 0; m_last_cpu = 1;
            m_main_we = 0; m_spec_we = 0; m_err = 0; m_busy = 0;
            m_main_addr = 0; m_spec_addr = 0; m_main_data = 0; m_spec_data = 0;
        end else begin
            if (m_clearing) begin
                v = 1; a = m_cnt; d = m_col;
                if (m_cnt == 38399) m_clearing = 0;
                else m_cnt++;
            end else if (clr_start) begin
                m_clearing = 1; m_cnt = 0; m_col = clr_color;
            end else if (e_p_ack) begin
                v = 1; a = p_addr; d = p_data; m_last_cpu = 0;
            end else if (e_c_ack) begin
                v = 1; a = c_addr; d = c_data; m_last_cpu = 1;
            end
            m_main_we = 0;
            m_spec_we = 0;
            if (v) begin
                if (a < 36800) begin
                    m_main_we = 1; m_main_addr = a; m_main_data = d;
                end else if (a < 38400) begin
                    m_spec_we = 1; m_spec_addr = a - 36800; m_spec_data = d;
                end else begin
                    m_err = 1;
                end
            end
            m_busy = m_clearing;
        end
        @(posedge clk);
        #1;
        check("main_we", main_we, m_main_we);
        check("main_addr", main_addr, m_main_addr);
        check("main_data", main_data, m_main_data);
        check("spec_we", spec_we, m_spec_we);
        check("spec_addr", spec_addr, m_spec_addr);
        check("spec_data", spec_data, m_spec_data);
        check("clr_busy", clr_busy, m_busy);
        check("err_oob", err_oob, m_err);
        if (main_we) n_main++;
        if (spec_we) n_spec++;
    endtask

    initial begin
        bit [3:0] p_seq, c_seq;
        int k;
        reset = 0; p_req = 0; c_req = 0; clr_start = 0;
        p_addr = 0; c_addr = 0; p_data = 0; c_data = 0; clr_color = 0;
        cycle();
        cycle();
        check("rst_main_we", main_we, 0);
        check("rst_err_oob", err_oob, 0);
        reset = 1;

        // Painter write to main buffer
        p_req = 1; p_addr = 100; p_data = 3'b101;
        cycle();
        p_req = 0;
        check("t1_main_we", main_we, 1);
        check("t1_main_addr", main_addr, 100);
        check("t1_main_data", main_data, 3'b101);
        check("t1_spec_we", spec_we, 0);

        // CPU write to special buffer
        c_req = 1; c_addr = 36805; c_data = 3'b011;
        cycle();
        c_req = 0;
        check("t2_spec_we", spec_we, 1);
        check("t2_spec_addr", spec_addr, 5);
        check("t2_spec_data", spec_data, 3'b011);
        check("t2_main_we", main_we, 0);

        // Contention for four cycles
        p_req = 1; p_addr = 10; p_data = 3'b001;
        c_req = 1; c_addr = 36900; c_data = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1;
            p_seq[i] = p_ack;
            c_seq[i] = c_ack;
            cycle();
        end
        p_req = 0; c_req = 0;
`ifdef ARB_FIXED_PRIO_EN
        check("t3_p_seq", p_seq, 4'b1111);
        check("t3_c_seq", c_seq, 4'b0000);
`else
        check("t3_p_seq", p_seq, 4'b0101);
        check("t3_c_seq", c_seq, 4'b1010);
`endif
        cycle();

        // Out-of-range address is consumed and flagged
        p_req = 1; p_addr = 38400; p_data = 3'b111;
        cycle();
        p_req = 0;
        check("t4_main_we", main_we, 0);
        check("t4_spec_we", spec_we, 0);
        check("t4_err_oob", err_oob, 1);
        p_req = 1; p_addr = 7; p_data = 3'b100;
        cycle();
        p_req = 0;
        check("t4_err_sticky", err_oob, 1);
        cycle();

        // Randomised traffic following the requester hold rule
        reset = 0;
        cycle();
        reset = 1;
        check("rnd_err_clear", err_oob, 0);
        p_req = 1'($urandom); p_addr = pick_addr(); p_data = 3'($urandom);
        c_req = 1'($urandom); c_addr = pick_addr(); c_data = 3'($urandom);
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (!p_req || e_p_ack) begin
                p_req = 1'($urandom); p_addr = pick_addr(); p_data = 3'($urandom);
            end
            if (!c_req || e_c_ack) begin
                c_req = 1'($urandom); c_addr = pick_addr(); c_data = 3'($urandom);
            end
        end
        p_req = 0; c_req = 0;
        cycle();

        // Full clear with a held Painter request and an ignored restart
        p_req = 1; p_addr = 200; p_data = 3'b001;
        clr_start = 1; clr_color = 3'b010;
        cycle();
        clr_start = 0;
        n_main = 0; n_spec = 0; k = 0;
        while (m_clearing && k < 40000) begin
            clr_start = (k == 5);
            clr_color = (k == 5) ? 3'b111 : 3'b010;
            cycle();
            k++;
        end
        clr_start = 0;
        check("t5_bound", k < 40000, 1);
        check("t5_main_writes", n_main, 36800);
        check("t5_spec_writes", n_spec, 1600);
        check("t5_last_spec", spec_addr, 1599);
        check("t5_busy_low", clr_busy, 0);
        #1;
        check("t5_held_ack", p_ack, 1);
        cycle();
        p_req = 0;
        cycle();

        // Reset in the middle of a clear
        clr_start = 1; clr_color = 3'b011;
        cycle();
        clr_start = 0;
        k = 0;
        while (m_cnt < 1000 && k < 2000) begin
            cycle();
            k++;
        end
        check("t6_bound", k < 2000, 1);
        reset = 0;
        cycle();
        check("t6_main_we", main_we, 0);
        check("t6_spec_we", spec_we, 0);
        check("t6_busy", clr_busy, 0);
        reset = 1;
        p_req = 1; p_addr = 50; p_data = 3'b110;
        cycle();
        p_req = 0;
        check("t6_main_we_after", main_we, 1);
        check("t6_main_addr_after", main_addr, 50);
        cycle();

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
